arp_request_gen: RTL and testbench
==================================

# arp_request_gen

Generates Ethernet ARP request frames for next-hops that missed in the router's ARP table, and sends them on the output AXI-Stream toward the output queues. It sits beside the ARP lookup stage in the router output-port-lookup pcore. On each miss, that stage pulses a strobe with the next-hop IP and the one-hot output queue. This block buffers the requests, suppresses rapid duplicates and emits one 60-byte broadcast ARP request per accepted miss on the egress port for that queue.

## Interface
Parameters:
- C_M_AXIS_DATA_WIDTH, 256, stream data width; only 256 is supported.
- C_M_AXIS_TUSER_WIDTH, 128, stream sideband width.
- SRC_PORT_POS, 16, bit offset of the source-port byte in TUSER.
- DST_PORT_POS, 24, bit offset of the destination-port byte in TUSER.
- REQ_FIFO_DEPTH_BITS, 2, log2 of the pending-request FIFO depth (default 4 entries).
- HOLDOFF_CYCLES, 1024, duplicate-suppression window in clock cycles.

Ports:
- AXI_ACLK  in  1  the only clock.
- AXI_RESETN  in  1  synchronous, active-low reset.
- miss_valid  in  1  single-cycle strobe: an ARP miss occurred.
- miss_ip  in  32  next-hop IPv4 address to resolve.
- miss_oq  in  8  one-hot egress port: 0x01, 0x04, 0x10 or 0x40.
- mac0..mac3  in  48 each  router MAC addresses of ports 0..3.
- ip0..ip3  in  32 each  router IPv4 addresses of ports 0..3.
- M_AXIS_TDATA  out  256  frame data; byte 0 of each beat is at [255:248].
- M_AXIS_TSTRB  out  32  byte enables; TSTRB[31-k] covers byte k of the beat.
- M_AXIS_TUSER  out  128  [15:0] length, [SRC_PORT_POS+7:SRC_PORT_POS] source port, [DST_PORT_POS+7:DST_PORT_POS] destination port; all other bits are 0.
- M_AXIS_TVALID  out  1  beat valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TLAST  out  1  last beat of the frame.
- req_sent_count  out  32  number of frames completed.
- req_drop_count  out  32  misses dropped because the FIFO was full or miss_oq was invalid.
- req_supp_count  out  32  misses suppressed as duplicates.

## Operation
- Enqueue: in each cycle with miss_valid=1, exactly one of the following applies, in priority order.
  - miss_oq is not one of the 4 legal values: drop the miss and increment req_drop_count.
  - miss_ip == last_ip and holdoff != 0: suppress the miss and increment req_supp_count.
  - The FIFO is full: drop the miss and increment req_drop_count.
  - Otherwise: write {miss_ip, miss_oq} into the FIFO.
- The enqueue comparison uses the registered last_ip and holdoff values from before any update in that same cycle.
- The miss_oq value selects the port index p: 0x01→0, 0x04→1, 0x10→2, 0x40→3. The MAC and IP of port p are sampled when an entry is popped.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop one entry, latch the frame fields, go to BEAT0.
  - BEAT0: TVALID=1, TLAST=0. On TREADY, load last_ip with the frame's target IP, load holdoff with HOLDOFF_CYCLES, go to BEAT1.
  - BEAT1: TVALID=1, TLAST=1. On TREADY, increment req_sent_count and go to IDLE.
- Beat0 layout (bytes 0-31):
  - Destination MAC ff:ff:ff:ff:ff:ff.
  - Source MAC = mac[p].
  - Ethertype 0x0806.
  - HTYPE 0x0001, PTYPE 0x0800, HLEN 6, PLEN 4, OPER 0x0001.
  - Sender hardware address = mac[p].
  - Sender protocol address = ip[p] (bytes 28-31).
  - TSTRB = 0xFFFFFFFF.
- Beat1 layout (bytes 32-63):
  - Target hardware address = 0 (bytes 32-37).
  - Target protocol address = miss_ip (bytes 38-41).
  - Bytes 42-59 = 0.
  - Bytes 60-63 = 0 and disabled; TSTRB = 0xFFFFFFF0.
- TUSER on both beats: length = 60, source port byte = 0, destination port byte = miss_oq.
- holdoff decrements by 1 per cycle and saturates at 0. A BEAT0 handshake reloads it; the reload wins over the decrement.
- All counters wrap modulo 2^32.

## Timing
- Reset values: TVALID=0, TLAST=0, TDATA=0, TSTRB=0, TUSER=0. All three counters = 0. FIFO empty, state IDLE, holdoff=0, last_ip=0.
- Latency: a strobe in cycle N into an empty FIFO with the FSM in IDLE gives TVALID=1 for BEAT0 in cycle N+2.
- AXI-Stream rules:
  - TDATA, TSTRB, TUSER and TLAST stay stable while TVALID=1 and TREADY=0.
  - TVALID never drops before its handshake.
- There is one IDLE bubble between consecutive frames. Sustained throughput is one frame per 3 cycles when TREADY is held high.
- An enqueue and a pop in the same cycle on a full FIFO: the enqueue is accepted.
- Reset asserted mid-frame: TVALID=0 on the next edge, the FIFO is flushed and the counters are cleared. No partial frame resumes after reset.

## Test plan
- Single miss: miss_ip=0x0A000102, miss_oq=0x04, mac1=0x001122334455, ip1=0x0A000101, TREADY=1 → two beats starting at N+2 with the exact byte layout above. TUSER[15:0]=60, TUSER[31:24]=0x04, req_sent_count=1.
- Backpressure: TREADY=0 for 10 cycles during BEAT0, then during BEAT1 → beat contents stay stable, no lost or duplicated beats, TLAST only on beat1.
- Duplicate: the same IP strobed 3 times within 100 cycles (HOLDOFF_CYCLES=1024) → one frame, req_supp_count=2. The same IP again after 1100 cycles → a second frame.
- Overflow: TREADY=0 and 6 distinct IPs strobed back-to-back → 5 entries held (4 in the FIFO plus 1 already popped into BEAT0), req_drop_count=1. After TREADY=1, 5 frames are emitted in FIFO order.
- Invalid port: miss_oq=0x02 → no frame, req_drop_count=1.
- Reset mid-BEAT1 → TVALID=0 next cycle and all counters are 0. A new miss after reset produces a complete frame.

Source files
------------

// File: rtl/arp_request_gen_if.sv
// AXI-Stream master channel carrying ARP request frames toward the output queues.
interface arp_request_gen_if #(
    parameter int DW = 256,
    parameter int UW = 128
);
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tstrb;
    logic [UW-1:0]   tuser;
    logic            tvalid;
    logic            tready;
    logic            tlast;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/arp_request_gen.sv
// ARP request generator: buffers ARP-table misses, suppresses rapid repeats of the
// same next-hop and emits one two-beat 60-byte broadcast ARP request per accepted miss.
//
// state   | meaning
// S_IDLE  | waiting for a pending request; pops one and latches its frame fields
// S_BEAT0 | presenting bytes 0-31 (Ethernet header + ARP sender fields)
// S_BEAT1 | presenting bytes 32-63 (ARP target fields + padding), TLAST=1
module arp_request_gen #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int SRC_PORT_POS         = 16,
    parameter int DST_PORT_POS         = 24,
    parameter int REQ_FIFO_DEPTH_BITS  = 2,
    parameter int HOLDOFF_CYCLES       = 1024
) (
    input  logic                 AXI_ACLK,
    input  logic                 AXI_RESETN,
    input  logic                 miss_valid,
    input  logic [31:0]          miss_ip,
    input  logic [7:0]           miss_oq,
    input  logic [47:0]          mac0,
    input  logic [47:0]          mac1,
    input  logic [47:0]          mac2,
    input  logic [47:0]          mac3,
    input  logic [31:0]          ip0,
    input  logic [31:0]          ip1,
    input  logic [31:0]          ip2,
    input  logic [31:0]          ip3,
    arp_request_gen_if.master    m_axis,
    output logic [31:0]          req_sent_count,
    output logic [31:0]          req_drop_count,
    output logic [31:0]          req_supp_count
);
    localparam int DEPTH = 1 << REQ_FIFO_DEPTH_BITS;
    localparam int PW    = REQ_FIFO_DEPTH_BITS;
    localparam int CW    = REQ_FIFO_DEPTH_BITS + 1;
    localparam int HW    = $clog2(HOLDOFF_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1} state_t;

    state_t        r_state, w_state_nxt;

    logic [39:0]   r_fifo_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_empty, w_full, w_push, w_pop, w_drop, w_supp, w_oq_legal, w_dup;
    logic [39:0]   w_head;
    logic [47:0]   w_head_mac;
    logic [31:0]   w_head_ip;

    logic [31:0]   r_tip, r_src_ip, r_last_ip;
    logic [47:0]   r_src_mac;
    logic [7:0]    r_oq;
    logic [HW-1:0] r_holdoff;
    logic [31:0]   r_sent, r_drop, r_supp;

    logic [C_M_AXIS_DATA_WIDTH-1:0]   w_tdata;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0] w_tstrb;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]  w_tuser, w_tuser_frame;
    logic                             w_tvalid, w_tlast, w_b0_hs;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    assign w_dup   = (miss_ip == r_last_ip) && (r_holdoff != '0);
    assign w_b0_hs = (r_state == S_BEAT0) && m_axis.tready;

    // Classify each miss strobe; a pop in the same cycle frees a slot in a full FIFO.
    always_comb begin
        w_oq_legal = 1'b0;
        w_push     = 1'b0;
        w_drop     = 1'b0;
        w_supp     = 1'b0;
        case (miss_oq)
            8'h01, 8'h04, 8'h10, 8'h40: w_oq_legal = 1'b1;
            default:                    w_oq_legal = 1'b0;
        endcase
        if (miss_valid) begin
            if (!w_oq_legal)             w_drop = 1'b1;
            else if (w_dup)              w_supp = 1'b1;
            else if (w_full && !w_pop)   w_drop = 1'b1;
            else                         w_push = 1'b1;
        end
    end

    // Pending-request FIFO pointers and occupancy.
    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_RESETN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage: {ip, one-hot oq}.
    always_ff @(posedge AXI_ACLK) begin
        if (w_push) r_fifo_mem[r_wr_ptr] <= {miss_ip, miss_oq};
    end

    // Router MAC/IP of the egress port named by the head entry.
    always_comb begin
        w_head = r_fifo_mem[r_rd_ptr];
        case (w_head[7:0])
            8'h04:   begin w_head_mac = mac1; w_head_ip = ip1; end
            8'h10:   begin w_head_mac = mac2; w_head_ip = ip2; end
            8'h40:   begin w_head_mac = mac3; w_head_ip = ip3; end
            default: begin w_head_mac = mac0; w_head_ip = ip0; end
        endcase
    end

    // Latch frame fields when an entry is popped.
    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_RESETN) begin
            r_tip     <= '0;
            r_oq      <= '0;
            r_src_mac <= '0;
            r_src_ip  <= '0;
        end else if (w_pop) begin
            r_tip     <= w_head[39:8];
            r_oq      <= w_head[7:0];
            r_src_mac <= w_head_mac;
            r_src_ip  <= w_head_ip;
        end
    end

    // Duplicate-suppression window, armed when a frame's first beat is accepted.
    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_RESETN) begin
            r_holdoff <= '0;
            r_last_ip <= '0;
        end else if (w_b0_hs) begin
            r_holdoff <= HW'(HOLDOFF_CYCLES);
            r_last_ip <= r_tip;
        end else if (r_holdoff != '0) begin
            r_holdoff <= r_holdoff - HW'(1);
        end
    end

    // Statistics counters.
    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_RESETN) begin
            r_sent <= '0;
            r_drop <= '0;
            r_supp <= '0;
        end else begin
            if ((r_state == S_BEAT1) && m_axis.tready) r_sent <= r_sent + 32'd1;
            if (w_drop) r_drop <= r_drop + 32'd1;
            if (w_supp) r_supp <= r_supp + 32'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_RESETN) r_state <= S_IDLE;
        else             r_state <= w_state_nxt;
    end

    // Sideband shared by both beats: length 60, source port 0, destination = one-hot oq.
    always_comb begin
        w_tuser_frame                      = '0;
        w_tuser_frame[15:0]                = 16'd60;
        w_tuser_frame[SRC_PORT_POS +: 8]   = 8'h00;
        w_tuser_frame[DST_PORT_POS +: 8]   = r_oq;
    end

    // FSM next state and stream outputs, all driven from registered frame fields.
    always_comb begin
        w_state_nxt = r_state;
        w_tvalid    = 1'b0;
        w_tlast     = 1'b0;
        w_tdata     = '0;
        w_tstrb     = '0;
        w_tuser     = '0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) w_state_nxt = S_BEAT0;
            end
            S_BEAT0: begin
                w_tvalid = 1'b1;
                w_tdata  = {48'hFFFF_FFFF_FFFF, r_src_mac, 16'h0806, 16'h0001, 16'h0800,
                            8'h06, 8'h04, 16'h0001, r_src_mac, r_src_ip};
                w_tstrb  = '1;
                w_tuser  = w_tuser_frame;
                if (m_axis.tready) w_state_nxt = S_BEAT1;
            end
            S_BEAT1: begin
                w_tvalid     = 1'b1;
                w_tlast      = 1'b1;
                w_tdata      = {48'h0, r_tip, 176'h0};
                w_tstrb      = '1;
                w_tstrb[3:0] = 4'h0;
                w_tuser      = w_tuser_frame;
                if (m_axis.tready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign m_axis.tdata    = w_tdata;
    assign m_axis.tstrb    = w_tstrb;
    assign m_axis.tuser    = w_tuser;
    assign m_axis.tvalid   = w_tvalid;
    assign m_axis.tlast    = w_tlast;
    assign req_sent_count  = r_sent;
    assign req_drop_count  = r_drop;
    assign req_supp_count  = r_supp;
endmodule

// File: tb/tb_arp_request_gen.sv
// Directed bench for arp_request_gen: expected frames are assembled byte by byte.
module tb_arp_request_gen;
    logic        clk;
    logic        rst_n;
    logic        miss_valid;
    logic [31:0] miss_ip;
    logic [7:0]  miss_oq;
    logic [47:0] mac0, mac1, mac2, mac3;
    logic [31:0] ip0, ip1, ip2, ip3;
    logic [31:0] sent_cnt, drop_cnt, supp_cnt;
    int          n_checks;
    int          n_errors;

    arp_request_gen_if #(.DW(256), .UW(128)) m_axis_if ();

    arp_request_gen dut (
        .AXI_ACLK       (clk),
        .AXI_RESETN     (rst_n),
        .miss_valid     (miss_valid),
        .miss_ip        (miss_ip),
        .miss_oq        (miss_oq),
        .mac0           (mac0),
        .mac1           (mac1),
        .mac2           (mac2),
        .mac3           (mac3),
        .ip0            (ip0),
        .ip1            (ip1),
        .ip2            (ip2),
        .ip3            (ip3),
        .m_axis         (m_axis_if.master),
        .req_sent_count (sent_cnt),
        .req_drop_count (drop_cnt),
        .req_supp_count (supp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] pack_bytes(input logic [7:0] b [32]);
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < 32; k++) v[255-8*k -: 8] = b[k];
        return v;
    endfunction

    function automatic logic [255:0] exp_beat0(input logic [47:0] mac, input logic [31:0] sip);
        logic [7:0] b [32];
        for (int i = 0; i < 32; i++) b[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            b[i]      = 8'hFF;
            b[6 + i]  = mac[47-8*i -: 8];
            b[22 + i] = mac[47-8*i -: 8];
        end
        b[12] = 8'h08; b[13] = 8'h06;
        b[15] = 8'h01;
        b[16] = 8'h08;
        b[18] = 8'h06; b[19] = 8'h04;
        b[21] = 8'h01;
        for (int i = 0; i < 4; i++) b[28 + i] = sip[31-8*i -: 8];
        return pack_bytes(b);
    endfunction

    function automatic logic [255:0] exp_beat1(input logic [31:0] tip);
        logic [7:0] b [32];
        for (int i = 0; i < 32; i++) b[i] = 8'h00;
        for (int i = 0; i < 4; i++) b[6 + i] = tip[31-8*i -: 8];
        return pack_bytes(b);
    endfunction

    function automatic logic [127:0] exp_tuser(input logic [7:0] oq);
        logic [127:0] t;
        t        = '0;
        t[15:0]  = 16'd60;
        t[31:24] = oq;
        return t;
    endfunction

    function automatic logic [47:0] port_mac(input logic [7:0] oq);
        case (oq)
            8'h04:   return mac1;
            8'h10:   return mac2;
            8'h40:   return mac3;
            default: return mac0;
        endcase
    endfunction

    function automatic logic [31:0] port_ip(input logic [7:0] oq);
        case (oq)
            8'h04:   return ip1;
            8'h10:   return ip2;
            8'h40:   return ip3;
            default: return ip0;
        endcase
    endfunction

    task automatic strobe(input logic [31:0] ip, input logic [7:0] oq);
        miss_valid = 1'b1;
        miss_ip    = ip;
        miss_oq    = oq;
        @(negedge clk);
        miss_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 50 && m_axis_if.tvalid !== 1'b1; i++) @(negedge clk);
        chk({tag, "_wait_valid"}, m_axis_if.tvalid, 1);
    endtask

    task automatic check_beat0(input string tag, input logic [7:0] oq);
        chk({tag, "_b0_tvalid"}, m_axis_if.tvalid, 1);
        chk({tag, "_b0_tlast"},  m_axis_if.tlast, 0);
        chk({tag, "_b0_tdata"},  m_axis_if.tdata, exp_beat0(port_mac(oq), port_ip(oq)));
        chk({tag, "_b0_tstrb"},  m_axis_if.tstrb, 32'hFFFF_FFFF);
        chk({tag, "_b0_tuser"},  m_axis_if.tuser, exp_tuser(oq));
    endtask

    task automatic check_beat1(input string tag, input logic [31:0] tip, input logic [7:0] oq);
        chk({tag, "_b1_tvalid"}, m_axis_if.tvalid, 1);
        chk({tag, "_b1_tlast"},  m_axis_if.tlast, 1);
        chk({tag, "_b1_tdata"},  m_axis_if.tdata, exp_beat1(tip));
        chk({tag, "_b1_tstrb"},  m_axis_if.tstrb, 32'hFFFF_FFF0);
        chk({tag, "_b1_tuser"},  m_axis_if.tuser, exp_tuser(oq));
    endtask

    // Expects TREADY held high.
    task automatic get_frame(input string tag, input logic [31:0] tip, input logic [7:0] oq);
        wait_valid(tag);
        check_beat0(tag, oq);
        @(negedge clk);
        check_beat1(tag, tip, oq);
        @(negedge clk);
    endtask

    task automatic hold_stable(input string tag, input logic exp_last);
        logic [255:0] d;
        logic [127:0] u;
        logic [31:0]  s;
        logic         ok;
        d  = m_axis_if.tdata;
        u  = m_axis_if.tuser;
        s  = m_axis_if.tstrb;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (m_axis_if.tvalid !== 1'b1 || m_axis_if.tlast !== exp_last ||
                m_axis_if.tdata !== d || m_axis_if.tuser !== u || m_axis_if.tstrb !== s)
                ok = 1'b0;
        end
        chk({tag, "_stable"}, ok, 1);
    endtask

    logic [31:0] ov_ip [6];
    logic [7:0]  ov_oq [6];
    logic        seen;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        miss_valid = 1'b0;
        miss_ip    = '0;
        miss_oq    = '0;
        m_axis_if.tready = 1'b0;
        mac0 = 48'h0200_0000_0A00; ip0 = 32'h0A00_0001;
        mac1 = 48'h0011_2233_4455; ip1 = 32'h0A00_0101;
        mac2 = 48'h0266_7788_99AA; ip2 = 32'h0A00_0201;
        mac3 = 48'h02BB_CCDD_EEFF; ip3 = 32'h0A00_0301;
        repeat (3) @(negedge clk);

        chk("rst_tvalid", m_axis_if.tvalid, 0);
        chk("rst_tlast",  m_axis_if.tlast, 0);
        chk("rst_tdata",  m_axis_if.tdata, 0);
        chk("rst_tstrb",  m_axis_if.tstrb, 0);
        chk("rst_tuser",  m_axis_if.tuser, 0);
        chk("rst_counts", {sent_cnt, drop_cnt, supp_cnt}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single miss with latency check.
        m_axis_if.tready = 1'b1;
        strobe(32'h0A00_0102, 8'h04);
        chk("single_n1_tvalid", m_axis_if.tvalid, 0);
        @(negedge clk);
        chk("single_n2_tvalid", m_axis_if.tvalid, 1);
        check_beat0("single", 8'h04);
        @(negedge clk);
        check_beat1("single", 32'h0A00_0102, 8'h04);
        @(negedge clk);
        chk("single_after_tvalid", m_axis_if.tvalid, 0);
        chk("single_sent", sent_cnt, 1);

        // Backpressure on each beat.
        m_axis_if.tready = 1'b0;
        strobe(32'h0A00_0305, 8'h01);
        wait_valid("bp");
        check_beat0("bp", 8'h01);
        hold_stable("bp_b0", 1'b0);
        m_axis_if.tready = 1'b1;
        @(negedge clk);
        m_axis_if.tready = 1'b0;
        check_beat1("bp", 32'h0A00_0305, 8'h01);
        hold_stable("bp_b1", 1'b1);
        m_axis_if.tready = 1'b1;
        @(negedge clk);
        chk("bp_after_tvalid", m_axis_if.tvalid, 0);
        chk("bp_sent", sent_cnt, 2);

        // Duplicate suppression and window expiry.
        strobe(32'h0A00_0407, 8'h10);
        get_frame("dup1", 32'h0A00_0407, 8'h10);
        repeat (10) @(negedge clk);
        strobe(32'h0A00_0407, 8'h10);
        repeat (40) @(negedge clk);
        strobe(32'h0A00_0407, 8'h10);
        repeat (5) @(negedge clk);
        chk("dup_supp", supp_cnt, 2);
        chk("dup_sent", sent_cnt, 3);
        chk("dup_idle", m_axis_if.tvalid, 0);
        repeat (1100) @(negedge clk);
        strobe(32'h0A00_0407, 8'h10);
        get_frame("dup2", 32'h0A00_0407, 8'h10);
        chk("dup2_sent", sent_cnt, 4);
        chk("dup2_supp", supp_cnt, 2);

        // Overflow: six back-to-back misses with the sink stalled.
        for (int i = 0; i < 6; i++) begin
            ov_ip[i] = 32'h0A00_0510 + 32'(i);
            ov_oq[i] = (i % 2 == 0) ? 8'h01 : 8'h40;
        end
        m_axis_if.tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            miss_valid = 1'b1;
            miss_ip    = ov_ip[i];
            miss_oq    = ov_oq[i];
            @(negedge clk);
        end
        miss_valid = 1'b0;
        @(negedge clk);
        chk("ov_drop", drop_cnt, 1);
        m_axis_if.tready = 1'b1;
        for (int i = 0; i < 5; i++) get_frame($sformatf("ov%0d", i), ov_ip[i], ov_oq[i]);
        repeat (5) @(negedge clk);
        chk("ov_sent", sent_cnt, 9);
        chk("ov_idle", m_axis_if.tvalid, 0);

        // Illegal one-hot port.
        strobe(32'h0A00_0601, 8'h02);
        seen = 1'b0;
        repeat (8) begin
            if (m_axis_if.tvalid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        chk("inv_no_frame", seen, 0);
        chk("inv_drop", drop_cnt, 2);

        // Reset during BEAT1, then a fresh frame.
        m_axis_if.tready = 1'b0;
        strobe(32'h0A00_0701, 8'h04);
        wait_valid("rst_mid");
        m_axis_if.tready = 1'b1;
        @(negedge clk);
        m_axis_if.tready = 1'b0;
        chk("rst_mid_in_beat1", m_axis_if.tlast, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_tvalid", m_axis_if.tvalid, 0);
        chk("rst_mid_sent", sent_cnt, 0);
        chk("rst_mid_drop", drop_cnt, 0);
        chk("rst_mid_supp", supp_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_no_resume", m_axis_if.tvalid, 0);
        m_axis_if.tready = 1'b1;
        strobe(32'h0A00_0801, 8'h40);
        get_frame("post_rst", 32'h0A00_0801, 8'h40);
        chk("post_rst_sent", sent_cnt, 1);
        repeat (3) @(negedge clk);
        chk("post_rst_idle", m_axis_if.tvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
